// File: rtl/rv4028_bus_arbiter.sv
// rv4028_bus_arbiter: two-master round-robin arbiter and strobe sequencer for the RV4028 16-bit bus,
// with a lock that keeps the grant across back-to-back halfwords.
module rv4028_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_msk_n,
  input  logic [15:0]       m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_msk_n,
  input  logic [15:0]       m1_wdata,
  output logic              m1_ack,
  output logic [15:0]       rdata,
  output logic              owner,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_n,
  output logic              wr_n,
  output logic [1:0]        msk_n,
  output logic              mreq_n,
  output logic              iorq_n,
  input  logic              wait_n,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_oe
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2;
  logic [1:0] state_q, state_d;
  logic last_owner_q, last_owner_d, locked_q, locked_d, owner_q, owner_d, we_q, we_d;
  logic m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [15:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] msk_q, msk_d;
  logic grant_v, grant, active;
  always_comb begin
    grant_v = locked_q ? (owner_q ? m1_req : m0_req) : (m0_req | m1_req);
    grant = locked_q ? owner_q : (m0_req & m1_req) ? ~last_owner_q : m1_req;
    state_d = state_q;
    last_owner_d = last_owner_q;
    locked_d = locked_q;
    owner_d = owner_q;
    we_d = we_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    msk_d = msk_q;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    if (state_q == IDLE) begin
      if (grant_v) begin
        owner_d = grant;
        addr_d = (grant ? m1_addr : m0_addr) & ~ADDR_W'(1);
        we_d = grant ? m1_we : m0_we;
        msk_d = grant ? m1_msk_n : m0_msk_n;
        wdata_d = grant ? m1_wdata : m0_wdata;
        state_d = ACCESS;
      end else if (locked_q) begin
        locked_d = 1'b0;
      end
    end else if (state_q == ACCESS) begin
      if (wait_n) begin
        rdata_d = we_q ? rdata_q : data_in;
        m0_ack_d = ~owner_q;
        m1_ack_d = owner_q;
        last_owner_d = owner_q;
        locked_d = owner_q ? m1_lock : m0_lock;
        state_d = ACK;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_owner_q <= 1'b1;
      locked_q <= 1'b0;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q <= '0;
      msk_q <= 2'b11;
    end else begin
      state_q <= state_d;
      last_owner_q <= last_owner_d;
      locked_q <= locked_d;
      owner_q <= owner_d;
      we_q <= we_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      msk_q <= msk_d;
    end
  end
  // Strobes decode from state only, so reset drops them asynchronously.
  assign active = state_q == ACCESS;
  assign mreq_n = ~active;
  assign rd_n = ~(active & ~we_q);
  assign wr_n = ~(active & we_q);
  assign data_oe = active & we_q;
  assign iorq_n = ~(active & addr_q[ADDR_W-1]);
  assign msk_n = msk_q;
  assign data_out = wdata_q;
  assign addr = addr_q;
  assign owner = owner_q;
  assign rdata = rdata_q;
  assign m0_ack = m0_ack_q;
  assign m1_ack = m1_ack_q;
endmodule

// File: tb/tb_rv4028_bus_arbiter.sv
// tb_rv4028_bus_arbiter: scoreboard bench; directed transactions push expected bus and ack
// records, and independent monitors pop and compare them as the DUT presents activity.
module tb_rv4028_bus_arbiter;
  typedef struct { logic we; logic lock; logic [31:0] addr; logic [1:0] msk; logic [15:0] wd; } txn_t;
  typedef struct { logic m; logic we; logic [31:0] addr; logic iorq_n; logic [1:0] msk; logic [15:0] wd; int lat; int len; } bus_t;
  typedef struct { logic m; logic [15:0] rd; int gap; } ack_t;

  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_lock = 0, m0_we = 0, m1_req = 0, m1_lock = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, addr;
  logic [1:0] m0_msk_n = 0, m1_msk_n = 0, msk_n;
  logic [15:0] m0_wdata = 0, m1_wdata = 0, rdata, data_in = 0, data_out;
  logic m0_ack, m1_ack, owner, rd_n, wr_n, mreq_n, iorq_n, data_oe;
  logic wait_n = 1;

  txn_t q0[$], q1[$];
  bus_t exp_bus[$];
  ack_t exp_ack[$];
  txn_t d0, d1;
  bus_t eb;
  ack_t ea;
  logic busy0 = 0, busy1 = 0, in_acc = 0, have_eb = 0;
  int cyc = 0, t0_0 = 0, t0_1 = 0, acc_len = 0, wait_cycles = 0, last_ack = 0;
  int n_tests = 0, n_fail = 0, n_bus = 0, n_ack = 0;

  rv4028_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_msk_n(m0_msk_n), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_msk_n(m1_msk_n), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .owner(owner), .addr(addr), .rd_n(rd_n), .wr_n(wr_n),
    .msk_n(msk_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .wait_n(wait_n),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic m, input logic we, input logic lock, input logic [31:0] a, input logic [1:0] msk, input logic [15:0] wd);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = a; t.msk = msk; t.wd = wd;
    if (m) q1.push_back(t); else q0.push_back(t);
  endtask

  task automatic exp_b(input logic m, input logic we, input logic [31:0] a, input logic io_n, input logic [1:0] msk, input logic [15:0] wd, input int lat, input int len);
    bus_t b;
    b.m = m; b.we = we; b.addr = a; b.iorq_n = io_n; b.msk = msk; b.wd = wd; b.lat = lat; b.len = len;
    exp_bus.push_back(b);
  endtask

  task automatic exp_a(input logic m, input logic [15:0] rd, input int gap);
    ack_t a;
    a.m = m; a.rd = rd; a.gap = gap;
    exp_ack.push_back(a);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_strobes"}, {rd_n, wr_n, mreq_n, iorq_n, data_oe}, 5'b11110);
    chk({nm, "_owner_acks"}, {owner, m0_ack, m1_ack}, 3'b000);
    chk({nm, "_rdata"}, rdata, 0);
    chk({nm, "_addr"}, addr, 0);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_msk_n"}, msk_n, 2'b11);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    while ((exp_bus.size() != 0 || exp_ack.size() != 0 || q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_in_time"}, n < bound, 1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); busy0 = 0; m0_req = 0; m0_lock = 0;
    end else begin
      if (busy0 && m0_ack) busy0 = 0;
      if (!busy0 && q0.size() != 0) begin
        d0 = q0.pop_front(); busy0 = 1; t0_0 = cyc;
        m0_req = 1; m0_lock = d0.lock; m0_we = d0.we; m0_addr = d0.addr; m0_msk_n = d0.msk; m0_wdata = d0.wd;
      end else if (!busy0) begin
        m0_req = 0; m0_lock = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete(); busy1 = 0; m1_req = 0; m1_lock = 0;
    end else begin
      if (busy1 && m1_ack) busy1 = 0;
      if (!busy1 && q1.size() != 0) begin
        d1 = q1.pop_front(); busy1 = 1; t0_1 = cyc;
        m1_req = 1; m1_lock = d1.lock; m1_we = d1.we; m1_addr = d1.addr; m1_msk_n = d1.msk; m1_wdata = d1.wd;
      end else if (!busy1) begin
        m1_req = 0; m1_lock = 0;
      end
    end
  end

  // Bus monitor: checks every ACCESS cycle against the expected record and drives wait_n.
  always @(negedge clk) begin
    if (!mreq_n && !in_acc) begin
      in_acc = 1; acc_len = 0;
      if (exp_bus.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_bus: addr %0h seen, none expected", addr);
      end else begin
        eb = exp_bus.pop_front(); have_eb = 1;
        chk("bus_owner", owner, eb.m);
        if (eb.lat != 0) chk("grant_latency", cyc - (eb.m ? t0_1 : t0_0), eb.lat);
      end
    end
    if (!mreq_n) begin
      acc_len++;
      wait_n = acc_len > wait_cycles;
      if (have_eb) begin
        chk("bus_addr", addr, eb.addr);
        chk("rd_wr_oe", {rd_n, wr_n, data_oe}, {eb.we, ~eb.we, eb.we});
        chk("iorq_n", iorq_n, eb.iorq_n);
        chk("bus_msk_n", msk_n, eb.msk);
        if (eb.we) chk("data_out", data_out, eb.wd);
      end
    end else begin
      wait_n = 1;
      if (in_acc) begin
        in_acc = 0; n_bus++;
        if (have_eb && eb.len != 0) chk("access_len", acc_len, eb.len);
        have_eb = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      chk("ack_exclusive", m0_ack & m1_ack, 0);
      if (exp_ack.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_ack: m0_ack=%0d m1_ack=%0d, none expected", m0_ack, m1_ack);
      end else begin
        ea = exp_ack.pop_front();
        chk("ack_master", m1_ack, ea.m);
        chk("ack_rdata", rdata, ea.rd);
        if (ea.gap != 0) chk("ack_spacing", cyc - last_ack, ea.gap);
      end
      last_ack = cyc; n_ack++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    @(posedge clk); #2 rst = 0;

    data_in = 16'hBEEF;
    exp_b(0, 0, 32'h0000_1234, 1, 2'b00, 16'h0, 1, 1);
    exp_a(0, 16'hBEEF, 0);
    issue(0, 0, 0, 32'h0000_1235, 2'b00, 16'h0);
    wait_idle("m0_read", 60);

    wait_cycles = 3;
    exp_b(1, 1, 32'h8000_0010, 0, 2'b10, 16'hA5A5, 1, 4);
    exp_a(1, 16'hBEEF, 0);
    issue(1, 1, 0, 32'h8000_0010, 2'b10, 16'hA5A5);
    wait_idle("m1_write_wait", 60);
    wait_cycles = 0;

    rst = 1; #1 check_reset("reset2");
    @(posedge clk); #2 rst = 0;
    data_in = 16'h3C3C;
    exp_b(0, 1, 32'h2000, 1, 2'b00, 16'h0A0A, 1, 1);
    exp_b(1, 0, 32'h3000, 1, 2'b01, 16'h0, 0, 1);
    exp_b(0, 0, 32'h2004, 1, 2'b00, 16'h0, 0, 1);
    exp_b(1, 1, 32'h3002, 1, 2'b11, 16'h0D0D, 0, 1);
    exp_a(0, 16'h0000, 0);
    exp_a(1, 16'h3C3C, 3);
    exp_a(0, 16'h3C3C, 3);
    exp_a(1, 16'h3C3C, 3);
    issue(0, 1, 0, 32'h2000, 2'b00, 16'h0A0A);
    issue(0, 0, 0, 32'h2004, 2'b00, 16'h0);
    issue(1, 0, 0, 32'h3000, 2'b01, 16'h0);
    issue(1, 1, 0, 32'h3002, 2'b11, 16'h0D0D);
    wait_idle("round_robin", 100);

    data_in = 16'h4444;
    exp_b(0, 0, 32'h100, 1, 2'b00, 16'h0, 1, 1);
    exp_b(0, 0, 32'h102, 1, 2'b00, 16'h0, 0, 1);
    exp_b(1, 1, 32'h500, 1, 2'b00, 16'h5555, 0, 1);
    exp_a(0, 16'h4444, 0);
    exp_a(0, 16'h4444, 3);
    exp_a(1, 16'h4444, 4);
    issue(0, 0, 1, 32'h100, 2'b00, 16'h0);
    issue(0, 0, 1, 32'h102, 2'b00, 16'h0);
    issue(1, 1, 0, 32'h500, 2'b00, 16'h5555);
    wait_idle("lock", 100);

    data_in = 16'h0;
    wait_cycles = 1000;
    exp_b(0, 0, 32'h40, 1, 2'b00, 16'h0, 1, 0);
    issue(0, 0, 0, 32'h41, 2'b00, 16'h0);
    for (int n = 0; n < 20 && mreq_n; n++) @(negedge clk);
    chk("abort_access_started", mreq_n, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 chk("abort_strobes", {rd_n, wr_n, mreq_n, iorq_n, data_oe}, 5'b11110);
    chk("abort_acks", {m0_ack, m1_ack}, 2'b00);
    @(posedge clk); #1 check_reset("abort_reset");
    #1 wait_cycles = 0; rst = 0;
    data_in = 16'h7777;
    exp_b(1, 0, 32'h8000_0100, 0, 2'b01, 16'h0, 1, 1);
    exp_a(1, 16'h7777, 0);
    issue(1, 0, 0, 32'h8000_0101, 2'b01, 16'h0);
    wait_idle("after_abort", 60);

    data_in = 16'h6666;
    exp_b(0, 0, 32'h600, 1, 2'b00, 16'h0, 1, 1);
    exp_b(0, 0, 32'h602, 1, 2'b01, 16'h0, 0, 1);
    exp_b(0, 0, 32'h604, 1, 2'b10, 16'h0, 0, 1);
    exp_a(0, 16'h6666, 0);
    exp_a(0, 16'h6666, 3);
    exp_a(0, 16'h6666, 3);
    issue(0, 0, 0, 32'h600, 2'b00, 16'h0);
    issue(0, 0, 0, 32'h602, 2'b01, 16'h0);
    issue(0, 0, 0, 32'h604, 2'b10, 16'h0);
    wait_idle("req_through_ack", 80);

    chk("bus_count_vs_acks_plus_abort", n_bus, n_ack + 1);
    chk("total_acks", n_ack, 13);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
